// File: rtl/ahb5_txn_gen_scoreboard.sv
// ---------------------------------------------------------------------------
// ahb5_txn_gen_scoreboard
//   Random AHB5 SINGLE-transfer master with an APB-side scoreboard. Each run
//   issues num_txn word transfers, spread over NUM_AHB channels by a Galois
//   LFSR. Every accepted address phase is logged in an expected-transfer FIFO
//   and checked against APB completions coming out of an AHB-to-APB bridge.
//
//   Ports
//     HCLK, HRESET          clock, synchronous active-high reset
//     start, num_txn        launch a run of num_txn transfers (sampled in IDLE)
//     HADDR..HNONSEC        per-channel AHB manager outputs
//     HREADY, HRESP         per-channel AHB completion inputs
//     PADDR..PSLVERR        APB side of the bridge (observed only)
//     busy, done            run in progress / one-cycle end-of-run pulse
//     mism_cnt, resp_cnt    saturating scoreboard and error-response counters
//
//   Transfers are not pipelined: the next address phase starts only after the
//   previous data phase has completed.
// ---------------------------------------------------------------------------

// One AHB channel: drives the bus only while it owns the address or data phase.
module ahb5_txn_lane #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              addr_act,
    input  logic              data_act,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic              write,
    input  logic              nonsec,
    output logic [ADDR_W-1:0] haddr,
    output logic [DATA_W-1:0] hwdata,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [1:0]        htrans,
    output logic              hsel,
    output logic              hnonsec
);
    assign haddr   = addr_act ? addr : '0;
    assign hwrite  = addr_act & write;
    assign hnonsec = addr_act & nonsec;
    assign htrans  = addr_act ? 2'b10 : 2'b00;
    assign hsel    = addr_act;
    assign hsize   = 3'b010;
    assign hwdata  = data_act ? data : '0;
endmodule

module ahb5_txn_gen_scoreboard #(
    parameter int          NUM_AHB   = 2,
    parameter int          ADDR_W    = 32,
    parameter int          DATA_W    = 32,
    parameter int          SB_DEPTH  = 8,
    parameter logic [31:0] SEED      = 32'hACE1_2468,
    parameter logic [31:0] ADDR_MASK = 32'h0000_0FFC
) (
    input  logic                             HCLK,
    input  logic                             HRESET,
    input  logic                             start,
    input  logic [15:0]                      num_txn,
    output logic [NUM_AHB-1:0][ADDR_W-1:0]   HADDR,
    output logic [NUM_AHB-1:0][DATA_W-1:0]   HWDATA,
    output logic [NUM_AHB-1:0]               HWRITE,
    output logic [NUM_AHB-1:0][2:0]          HSIZE,
    output logic [NUM_AHB-1:0][1:0]          HTRANS,
    output logic [NUM_AHB-1:0]               HSEL,
    output logic [NUM_AHB-1:0]               HNONSEC,
    input  logic [NUM_AHB-1:0]               HREADY,
    input  logic [NUM_AHB-1:0]               HRESP,
    input  logic [ADDR_W-1:0]                PADDR,
    input  logic [DATA_W-1:0]                PWDATA,
    input  logic                             PWRITE,
    input  logic                             PSEL,
    input  logic                             PENABLE,
    input  logic                             PREADY,
    input  logic                             PSLVERR,
    output logic                             busy,
    output logic                             done,
    output logic [15:0]                      mism_cnt,
    output logic [15:0]                      resp_cnt
);
    localparam int CW = (NUM_AHB > 1) ? $clog2(NUM_AHB) : 1;
    localparam int PW = $clog2(SB_DEPTH);
    localparam logic [31:0] TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DRAIN} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              write;
    } sb_entry_t;

    state_t            state, state_nxt;
    logic [31:0]       lfsr;
    logic [15:0]       remain;
    logic [CW-1:0]     dchan;
    logic [DATA_W-1:0] ddata;

    sb_entry_t         fifo [SB_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       count;

    // Random fields of the transfer about to be issued (current LFSR value).
    logic [CW-1:0]     chan;
    logic [ADDR_W-1:0] addr_rnd;
    logic [DATA_W-1:0] data_rnd;

    assign chan     = CW'(lfsr[15:0] % 16'(NUM_AHB));
    assign addr_rnd = ADDR_W'(lfsr & ADDR_MASK & ~32'h3);
    if (DATA_W >= 64) begin : g_data64
        assign data_rnd = DATA_W'({lfsr, ~lfsr});
    end else begin : g_data32
        assign data_rnd = DATA_W'(~lfsr);
    end

    logic full, empty, issue, accept, data_act, data_fin, done_set;
    logic apb_fin, pop, mism_hit;
    sb_entry_t head;

    assign full     = (count == (PW+1)'(SB_DEPTH));
    assign empty    = (count == '0);
    assign data_fin = (state == S_DATA) && HREADY[dchan];
    assign apb_fin  = PSEL & PENABLE & PREADY;
    assign pop      = apb_fin & ~empty;
    assign head     = fifo[rd_ptr];
    // A completion with nothing expected is itself a mismatch.
    assign mism_hit = apb_fin & (empty | (head.addr != PADDR) | (head.write != PWRITE) |
                                 (head.write & (head.data != PWDATA)));

    // ---- FSM: state register ----
    always_ff @(posedge HCLK) begin
        if (HRESET) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start && num_txn != 16'd0) state_nxt = S_ADDR;
            S_ADDR:  if (accept)                    state_nxt = S_DATA;
            S_DATA:  if (data_fin)                  state_nxt = (remain != 16'd0) ? S_ADDR : S_DRAIN;
            S_DRAIN: if (empty)                     state_nxt = S_IDLE;
            default:                                state_nxt = S_IDLE;
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        busy     = (state != S_IDLE);
        // A full FIFO parks the bus at IDLE rather than issuing a transfer it cannot log.
        issue    = (state == S_ADDR) && !full;
        accept   = issue && HREADY[chan];
        data_act = (state == S_DATA);
        done_set = ((state == S_IDLE) && start && num_txn == 16'd0) ||
                   ((state == S_DRAIN) && empty);
    end

    // ---- datapath, pointers, counters ----
    logic [1:0]  resp_inc;
    logic [16:0] resp_sum;
    assign resp_inc = {1'b0, data_fin & HRESP[dchan]} + {1'b0, apb_fin & PSLVERR};
    assign resp_sum = {1'b0, resp_cnt} + 17'(resp_inc);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            lfsr     <= SEED;
            remain   <= '0;
            dchan    <= '0;
            ddata    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            done     <= 1'b0;
            mism_cnt <= '0;
            resp_cnt <= '0;
        end else begin
            done <= done_set;
            if (state == S_IDLE && start) remain <= num_txn;
            if (accept) begin
                wr_ptr <= wr_ptr + PW'(1);
                lfsr   <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'h0);
                remain <= remain - 16'd1;
                dchan  <= chan;
                ddata  <= data_rnd;
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({accept, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
            if (mism_hit && mism_cnt != 16'hFFFF) mism_cnt <= mism_cnt + 16'd1;
            resp_cnt <= resp_sum[16] ? 16'hFFFF : resp_sum[15:0];
        end
    end

    // Storage needs no reset: occupancy is tracked by count.
    always_ff @(posedge HCLK) begin
        if (accept) fifo[wr_ptr] <= '{addr: addr_rnd, data: data_rnd, write: lfsr[31]};
    end

    // ---- per-channel bus drivers ----
    for (genvar g = 0; g < NUM_AHB; g++) begin : g_lane
        ahb5_txn_lane #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_lane (
            .addr_act (issue && chan == CW'(g)),
            .data_act (data_act && dchan == CW'(g)),
            .addr     (addr_rnd),
            .data     (ddata),
            .write    (lfsr[31]),
            .nonsec   (lfsr[30]),
            .haddr    (HADDR[g]),
            .hwdata   (HWDATA[g]),
            .hwrite   (HWRITE[g]),
            .hsize    (HSIZE[g]),
            .htrans   (HTRANS[g]),
            .hsel     (HSEL[g]),
            .hnonsec  (HNONSEC[g])
        );
    end
endmodule

// File: tb/tb_ahb5_txn_gen_scoreboard.sv
// ---------------------------------------------------------------------------
// Bench for ahb5_txn_gen_scoreboard. A cycle task samples the DUT on the
// falling edge (AHB monitor, expected-transfer model, APB completion count)
// and drives the next inputs 1 ns after the rising edge (AHB slave ready /
// response, AHB-to-APB bridge model echoing completed AHB transfers).
// ---------------------------------------------------------------------------
module tb_ahb5_txn_gen_scoreboard;
    localparam int          NUM_AHB  = 2;
    localparam int          ADDR_W   = 32;
    localparam int          DATA_W   = 32;
    localparam int          SB_DEPTH = 8;
    localparam logic [31:0] SEED     = 32'hACE1_2468;
    localparam logic [31:0] MASK     = 32'h0000_0FFC;

    logic                           HCLK = 1'b0;
    logic                           HRESET, start;
    logic [15:0]                    num_txn;
    logic [NUM_AHB-1:0][ADDR_W-1:0] HADDR;
    logic [NUM_AHB-1:0][DATA_W-1:0] HWDATA;
    logic [NUM_AHB-1:0]             HWRITE, HSEL, HNONSEC, HREADY, HRESP;
    logic [NUM_AHB-1:0][2:0]        HSIZE;
    logic [NUM_AHB-1:0][1:0]        HTRANS;
    logic [ADDR_W-1:0]              PADDR;
    logic [DATA_W-1:0]              PWDATA;
    logic                           PWRITE, PSEL, PENABLE, PREADY, PSLVERR;
    logic                           busy, done;
    logic [15:0]                    mism_cnt, resp_cnt;

    ahb5_txn_gen_scoreboard #(
        .NUM_AHB(NUM_AHB), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SB_DEPTH(SB_DEPTH),
        .SEED(SEED), .ADDR_MASK(MASK)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .start(start), .num_txn(num_txn),
        .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HTRANS(HTRANS), .HSEL(HSEL), .HNONSEC(HNONSEC), .HREADY(HREADY), .HRESP(HRESP),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PREADY(PREADY), .PSLVERR(PSLVERR),
        .busy(busy), .done(done), .mism_cnt(mism_cnt), .resp_cnt(resp_cnt)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              write;
    } xfer_t;

    xfer_t             bq[$];          // completed AHB transfers awaiting the APB bridge
    int                tests = 0, fails = 0;
    int                accepts, pops, done_cnt, exp_resp, apb_idx, corrupt_idx, apb_st, dch;
    logic [31:0]       m_lfsr;
    bit                dph, apb_fin;
    logic              dwr;
    logic [ADDR_W-1:0] dad;
    logic [DATA_W-1:0] dexp;
    bit                hready_rand, pready_rand, err_rand;
    logic [NUM_AHB-1:0] hready_val;
    logic              pready_val;
    logic [NUM_AHB-1:0][ADDR_W-1:0] h_addr0;
    logic [NUM_AHB-1:0][1:0]        h_trans0;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        xfer_t e;
        logic [63:0] d64;
        @(negedge HCLK);
        if (!HRESET) begin
            apb_fin = PSEL && PENABLE && PREADY;
            if (apb_fin) begin
                pops++;
                if (PSLVERR) exp_resp++;
            end
            if (dph && HREADY[dch]) begin
                if (HRESP[dch]) exp_resp++;
                if (dwr) chk("hwdata", 64'(HWDATA[dch]), 64'(dexp));
                bq.push_back('{addr: dad, data: HWDATA[dch], write: dwr});
                dph = 0;
            end
            for (int c = 0; c < NUM_AHB; c++) begin
                if (HTRANS[c] == 2'b10 && HREADY[c]) begin
                    chk("chan", 64'(c), 64'(m_lfsr[15:0] % NUM_AHB));
                    chk("haddr", 64'(HADDR[c]), 64'(m_lfsr & MASK));
                    chk("hwrite", 64'(HWRITE[c]), 64'(m_lfsr[31]));
                    chk("hnonsec", 64'(HNONSEC[c]), 64'(m_lfsr[30]));
                    chk("hsel", 64'(HSEL[c]), 64'd1);
                    d64  = {m_lfsr, ~m_lfsr};
                    dexp = d64[DATA_W-1:0];
                    dph = 1; dch = c; dwr = HWRITE[c]; dad = HADDR[c];
                    m_lfsr = lfsr_step(m_lfsr);
                    accepts++;
                end
            end
            if (done) done_cnt++;
        end
        @(posedge HCLK);
        #1;
        if (HRESET) return;
        // APB bridge: SETUP -> ACCESS (wait PREADY) -> next
        if (apb_st == 2) begin
            if (apb_fin) begin
                PSEL = 0; PENABLE = 0; PREADY = 0; PSLVERR = 0; apb_st = 0;
            end else begin
                PREADY = pready_rand ? ($urandom_range(0, 2) != 0) : pready_val;
            end
        end else if (apb_st == 1) begin
            PENABLE = 1; apb_st = 2;
            PREADY  = pready_rand ? ($urandom_range(0, 2) != 0) : pready_val;
            PSLVERR = err_rand ? ($urandom_range(0, 4) == 0) : 1'b0;
        end
        if (apb_st == 0 && bq.size() > 0) begin
            e = bq.pop_front();
            PSEL = 1; PENABLE = 0; PREADY = 0;
            PADDR  = e.addr ^ ((apb_idx == corrupt_idx) ? 32'h4 : 32'h0);
            PWDATA = e.data; PWRITE = e.write;
            apb_idx++; apb_st = 1;
        end
        // AHB slave
        for (int c = 0; c < NUM_AHB; c++)
            HREADY[c] = hready_rand ? ($urandom_range(0, 3) != 0) : hready_val[c];
        HRESP = '0;
        if (err_rand && dph && HREADY[dch]) HRESP[dch] = ($urandom_range(0, 3) == 0);
    endtask

    task automatic do_reset(input int n);
        HRESET = 1; start = 0; num_txn = 0;
        PSEL = 0; PENABLE = 0; PREADY = 0; PSLVERR = 0; PADDR = '0; PWDATA = '0; PWRITE = 0;
        hready_rand = 0; pready_rand = 0; err_rand = 0; hready_val = '1; pready_val = 1;
        HREADY = '1; HRESP = '0;
        bq.delete(); dph = 0; apb_st = 0; m_lfsr = SEED; apb_idx = 0; corrupt_idx = -1;
        repeat (n) cyc();
        HRESET = 0;
        accepts = 0; pops = 0; done_cnt = 0; exp_resp = 0;
    endtask

    task automatic kick(input logic [15:0] n);
        start = 1; num_txn = n;
        cyc();
        start = 0;
    endtask

    task automatic run_until_done(input int budget);
        int d0 = done_cnt;
        int n  = 0;
        while (done_cnt == d0 && n < budget) begin cyc(); n++; end
        chk("done_seen", 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        // T1 reset
        do_reset(2);
        chk("rst_htrans", 64'(HTRANS), 64'd0);
        chk("rst_hsel",   64'(HSEL),   64'd0);
        chk("rst_haddr",  64'(HADDR),  64'd0);
        chk("rst_hsize",  64'(HSIZE),  64'(6'b010_010));
        chk("rst_busy",   64'(busy),   64'd0);
        chk("rst_done",   64'(done),   64'd0);
        chk("rst_mism",   64'(mism_cnt), 64'd0);
        chk("rst_resp",   64'(resp_cnt), 64'd0);

        // zero-length run: done next cycle, never busy
        kick(16'd0);
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_busy", 64'(busy), 64'd0);
        cyc();
        chk("zero_done_pulse", 64'(done), 64'd0);

        // T2 single transfer
        do_reset(1);
        kick(16'd1);
        chk("t2_haddr0",  64'(HADDR[0]), 64'(SEED & MASK));
        chk("t2_htrans0", 64'(HTRANS[0]), 64'd2);
        chk("t2_htrans1", 64'(HTRANS[1]), 64'd0);
        chk("t2_busy",    64'(busy), 64'd1);
        run_until_done(100);
        chk("t2_busy_end", 64'(busy), 64'd0);
        chk("t2_accepts", 64'(accepts), 64'd1);
        chk("t2_pops",    64'(pops), 64'd1);
        chk("t2_mism",    64'(mism_cnt), 64'd0);
        cyc();
        chk("t2_done_pulse", 64'(done), 64'd0);

        // T3 scoreboard back-pressure
        do_reset(1);
        pready_val = 0;
        kick(16'd20);
        repeat (40) cyc();
        chk("t3_stall_accepts", 64'(accepts), 64'(SB_DEPTH));
        chk("t3_stall_htrans",  64'(HTRANS), 64'd0);
        chk("t3_stall_busy",    64'(busy), 64'd1);
        pready_val = 1;
        run_until_done(600);
        chk("t3_accepts", 64'(accepts), 64'd20);
        chk("t3_pops",    64'(pops), 64'd20);
        chk("t3_mism",    64'(mism_cnt), 64'd0);

        // T4 HREADY wait states in address phase
        do_reset(1);
        hready_val = '0; HREADY = '0;
        kick(16'd1);
        h_addr0 = HADDR; h_trans0 = HTRANS;
        chk("t4_nonseq", 64'(h_trans0), 64'(4'b0010));
        repeat (2) begin
            cyc();
            chk("t4_haddr_hold",  64'(HADDR),  64'(h_addr0));
            chk("t4_htrans_hold", 64'(HTRANS), 64'(h_trans0));
        end
        chk("t4_no_accept", 64'(accepts), 64'd0);
        hready_val = '1; HREADY = '1;
        run_until_done(100);
        chk("t4_accepts", 64'(accepts), 64'd1);
        chk("t4_mism",    64'(mism_cnt), 64'd0);

        // T5 corrupted bridge address, then a spurious APB completion
        do_reset(1);
        corrupt_idx = 1;
        kick(16'd4);
        run_until_done(200);
        chk("t5_mism_corrupt", 64'(mism_cnt), 64'd1);
        chk("t5_pops", 64'(pops), 64'd4);
        bq.push_back('{addr: 32'h123, data: 32'h5A5A_0000, write: 1'b1});
        repeat (6) cyc();
        chk("t5_mism_spurious", 64'(mism_cnt), 64'd2);
        chk("t5_busy", 64'(busy), 64'd0);

        // T6 reset mid-run, then a clean run
        do_reset(1);
        pready_val = 0;
        kick(16'd10);
        begin
            int n = 0;
            while (accepts < 5 && n < 200) begin cyc(); n++; end
        end
        chk("t6_accepts_pre", 64'(accepts), 64'd5);
        do_reset(1);
        chk("t6_busy",   64'(busy), 64'd0);
        chk("t6_htrans", 64'(HTRANS), 64'd0);
        chk("t6_done",   64'(done), 64'd0);
        chk("t6_mism",   64'(mism_cnt), 64'd0);
        repeat (4) cyc();
        chk("t6_no_done", 64'(done_cnt), 64'd0);
        kick(16'd3);
        run_until_done(200);
        chk("t6_accepts", 64'(accepts), 64'd3);
        chk("t6_mism_clean", 64'(mism_cnt), 64'd0);

        // randomized run with wait states and error responses
        do_reset(1);
        hready_rand = 1; pready_rand = 1; err_rand = 1;
        kick(16'd30);
        run_until_done(3000);
        chk("rnd_accepts", 64'(accepts), 64'd30);
        chk("rnd_pops",    64'(pops), 64'd30);
        chk("rnd_mism",    64'(mism_cnt), 64'd0);
        chk("rnd_resp",    64'(resp_cnt), 64'(exp_resp));
        chk("rnd_busy",    64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
